// File: rtl/branch_sequencer_pkg.sv
// Shared control definitions: opcodes, C2 branch condition codes and T-step
// state numbering, common to the branch sequencer and the main control unit.
package branch_sequencer_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;

    typedef enum logic [1:0] {
        C2_ZERO    = 2'b00,
        C2_NONZERO = 2'b01,
        C2_PLUS    = 2'b10,
        C2_MINUS   = 2'b11
    } c2_cond_t;

    // State codes equal the T-step number so the main unit can share them.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_FIN  = 3'd7
    } state_t;

endpackage

// File: rtl/br_stat_counter.sv
// Wrapping statistics counter with synchronous clear and single-step increment.
module br_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Execute-phase sequencer for the conditional branch: walks T3..T6, commits
// the PC load only when CON is set, and keeps taken / not-taken statistics.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = OP_BR,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [31:0]      IRIn,
    input  logic             CON,
    output logic             Gra,
    output logic             Rout,
    output logic             CONIn,
    output logic             PCout,
    output logic             Yin,
    output logic             Cout,
    output logic             ALU_ADD,
    output logic             Zin,
    output logic             Zlowout,
    output logic             PCIn,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    state_t state_reg, state_next;
    logic   illegal_reg;
    logic   is_branch;
    logic   unused_ir;

    assign is_branch = (IRIn[31:27] == BR_OPCODE);
    // Only the opcode matters here; register fields belong to the datapath.
    assign unused_ir = ^IRIn[26:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= ST_IDLE;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start && !is_branch) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start && is_branch) state_next = ST_T3;
            ST_T3:   state_next = ST_T4;
            ST_T4:   state_next = ST_T5;
            ST_T5:   state_next = ST_T6;
            ST_T6:   state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONIn   = 1'b0;
        PCout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ALU_ADD = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCIn    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_reg)
            ST_T3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONIn = 1'b1;
            end
            ST_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            ST_T5: begin
                Cout    = 1'b1;
                ALU_ADD = 1'b1;
                Zin     = 1'b1;
            end
            ST_T6: begin
                Zlowout = 1'b1;
                PCIn    = CON;
            end
            ST_FIN:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign illegal = illegal_reg;

    // Index 0 counts taken branches, index 1 not-taken.
    logic [1:0]            inc;
    logic [1:0][CNT_W-1:0] cnt;

    assign inc[0] = (state_reg == ST_T6) &&  CON;
    assign inc[1] = (state_reg == ST_T6) && !CON;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            br_stat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .clr   (clr),
                .inc   (inc[gi]),
                .count (cnt[gi])
            );
        end
    endgenerate

    assign taken_cnt    = cnt[0];
    assign nottaken_cnt = cnt[1];

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: per-cycle vector table plus sequences
// for mid-flight reset and counter wrap on a narrow-counter instance.
module tb_branch_sequencer;

    localparam logic [31:0] BRZR  = 32'h9000_0000;
    localparam logic [31:0] BRNZ  = 32'h9008_0005;
    localparam logic [31:0] NOTBR = 32'h0800_0000;

    // {Gra,Rout,CONIn,PCout,Yin,Cout,ALU_ADD,Zin,Zlowout,PCIn,busy,done}
    localparam logic [11:0] O_IDLE = 12'b0000_0000_0000;
    localparam logic [11:0] O_T3   = 12'b1110_0000_0010;
    localparam logic [11:0] O_T4   = 12'b0001_1000_0010;
    localparam logic [11:0] O_T5   = 12'b0000_0111_0010;
    localparam logic [11:0] O_T6TK = 12'b0000_0000_1110;
    localparam logic [11:0] O_T6NT = 12'b0000_0000_1010;
    localparam logic [11:0] O_FIN  = 12'b0000_0000_0011;

    logic clk = 1'b0;
    logic clr, start, con;
    logic [31:0] ir;

    logic Gra, Rout, CONIn, PCout, Yin, Cout, ALU_ADD, Zin, Zlowout, PCIn, busy, done, illegal;
    logic [15:0] taken_cnt, nottaken_cnt;
    logic Gra2, Rout2, CONIn2, PCout2, Yin2, Cout2, ALU_ADD2, Zin2, Zlowout2, PCIn2, busy2, done2, illegal2;
    logic [1:0] taken_cnt2, nottaken_cnt2;

    always #5 clk = ~clk;

    branch_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .IRIn(ir), .CON(con),
        .Gra(Gra), .Rout(Rout), .CONIn(CONIn), .PCout(PCout), .Yin(Yin),
        .Cout(Cout), .ALU_ADD(ALU_ADD), .Zin(Zin), .Zlowout(Zlowout), .PCIn(PCIn),
        .busy(busy), .done(done), .illegal(illegal),
        .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
    );

    branch_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .clr(clr), .start(start), .IRIn(ir), .CON(con),
        .Gra(Gra2), .Rout(Rout2), .CONIn(CONIn2), .PCout(PCout2), .Yin(Yin2),
        .Cout(Cout2), .ALU_ADD(ALU_ADD2), .Zin(Zin2), .Zlowout(Zlowout2), .PCIn(PCIn2),
        .busy(busy2), .done(done2), .illegal(illegal2),
        .taken_cnt(taken_cnt2), .nottaken_cnt(nottaken_cnt2)
    );

    typedef struct {
        logic        clr;
        logic        start;
        logic [31:0] ir;
        logic        con;
        logic [11:0] out;
        logic        ill;
        logic [15:0] tk;
        logic [15:0] nt;
    } vec_t;

    vec_t vec [0:21];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic s, input logic [31:0] i, input logic c,
                                input logic [11:0] o, input logic il,
                                input logic [15:0] t, input logic [15:0] n);
        vec_t v;
        v.clr = 1'b0; v.start = s; v.ir = i; v.con = c;
        v.out = o; v.ill = il; v.tk = t; v.nt = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [11:0] outs();
        return {Gra, Rout, CONIn, PCout, Yin, Cout, ALU_ADD, Zin, Zlowout, PCIn, busy, done};
    endfunction

    // Starts a branch on the next falling edge and returns cycles until done (-1 on timeout).
    task automatic run_branch(input logic [31:0] i, input logic c, output int lat);
        @(negedge clk);
        start = 1'b1; ir = i; con = c;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done2) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;

        vec[0]  = mk(0, 32'h0, 0, O_IDLE, 0, 0, 0);
        vec[1]  = mk(1, BRZR,  1, O_IDLE, 0, 0, 0);
        vec[2]  = mk(0, BRZR,  1, O_T3,   0, 0, 0);
        vec[3]  = mk(0, NOTBR, 1, O_T4,   0, 0, 0);
        vec[4]  = mk(0, NOTBR, 1, O_T5,   0, 0, 0);
        vec[5]  = mk(0, NOTBR, 1, O_T6TK, 0, 0, 0);
        vec[6]  = mk(0, NOTBR, 0, O_FIN,  0, 1, 0);
        vec[7]  = mk(1, BRNZ,  0, O_IDLE, 0, 1, 0);
        vec[8]  = mk(0, BRNZ,  0, O_T3,   0, 1, 0);
        vec[9]  = mk(1, BRZR,  0, O_T4,   0, 1, 0);
        vec[10] = mk(1, NOTBR, 0, O_T5,   0, 1, 0);
        vec[11] = mk(0, BRNZ,  0, O_T6NT, 0, 1, 0);
        vec[12] = mk(0, BRNZ,  0, O_FIN,  0, 1, 1);
        vec[13] = mk(1, NOTBR, 0, O_IDLE, 0, 1, 1);
        vec[14] = mk(0, NOTBR, 0, O_IDLE, 1, 1, 1);
        vec[15] = mk(1, BRZR,  1, O_IDLE, 1, 1, 1);
        vec[16] = mk(0, BRZR,  1, O_T3,   1, 1, 1);
        vec[17] = mk(0, BRZR,  1, O_T4,   1, 1, 1);
        vec[18] = mk(0, BRZR,  1, O_T5,   1, 1, 1);
        vec[19] = mk(0, BRZR,  1, O_T6TK, 1, 1, 1);
        vec[20] = mk(0, BRZR,  0, O_FIN,  1, 2, 1);
        vec[21] = mk(0, BRZR,  0, O_IDLE, 1, 2, 1);

        clr = 1'b1; start = 1'b0; ir = 32'h0; con = 1'b0;
        repeat (2) @(posedge clk);

        // Inputs applied at the falling edge; outputs checked before the next rising edge.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            clr = vec[i].clr; start = vec[i].start; ir = vec[i].ir; con = vec[i].con;
            #1;
            check($sformatf("row%0d_strobes", i), 32'(outs()), 32'(vec[i].out));
            check($sformatf("row%0d_illegal", i), 32'(illegal), 32'(vec[i].ill));
            check($sformatf("row%0d_taken", i), 32'(taken_cnt), 32'(vec[i].tk));
            check($sformatf("row%0d_nottaken", i), 32'(nottaken_cnt), 32'(vec[i].nt));
        end

        // Second start during T4, then clr in T5: sequence aborts, nothing queued.
        @(negedge clk); start = 1'b1; ir = BRZR; con = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; #1;
        check("abort_t4", 32'(outs()), 32'(O_T4));
        @(negedge clk); start = 1'b0; clr = 1'b1; #1;
        check("abort_t5", 32'(outs()), 32'(O_T5));
        @(negedge clk); clr = 1'b0; #1;
        check("abort_idle", 32'(outs()), 32'(O_IDLE));
        check("abort_taken", 32'(taken_cnt), 32'd0);
        check("abort_illegal", 32'(illegal), 32'd0);
        @(negedge clk); #1;
        check("abort_no_queue", 32'(outs()), 32'(O_IDLE));
        check("abort_taken_w2", 32'(taken_cnt2), 32'd0);

        // Four back-to-back taken branches: 2-bit counter wraps, 16-bit does not.
        for (int k = 0; k < 4; k++) begin
            run_branch(BRZR, 1'b1, lat);
            check($sformatf("wrap%0d_latency", k), 32'(lat), 32'd5);
            check($sformatf("wrap%0d_taken_w2", k), 32'(taken_cnt2), 32'((k + 1) % 4));
            check($sformatf("wrap%0d_taken", k), 32'(taken_cnt), 32'(k + 1));
        end
        @(negedge clk); #1;
        check("wrap_nottaken_w2", 32'(nottaken_cnt2), 32'd0);
        check("wrap_idle", 32'(outs()), 32'(O_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Execute-phase control sequencer for the conditional-branch instruction (br, C2 condition field in IR[20:19]).
- Consumes the IR and the CON flag from the CON flip-flop logic; drives the CON flip-flop enable (CONIn) and the datapath strobes for the T3..T6 branch steps.
- Commits the PC update only when CON is high.
- Sits beside the main control unit, which hands over via start after fetch (T0..T2) and resumes on done.

Parameters:
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a branch
- CNT_W, 16, width of the taken / not-taken statistics counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- clr  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse from main control unit: IR holds a fetched instruction, begin branch execute
- IRIn  in  32  instruction register contents
- CON  in  1  condition flag from CON flip-flop logic
- Gra  out  1  select Ra field for register-file output
- Rout  out  1  register-file drive onto bus
- CONIn  out  1  CON flip-flop load enable
- PCout  out  1  PC drive onto bus
- Yin  out  1  Y register load
- Cout  out  1  sign-extended C field drive onto bus
- ALU_ADD  out  1  ALU add select
- Zin  out  1  Z register load
- Zlowout  out  1  Z low word drive onto bus
- PCIn  out  1  PC load
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse, hand control back
- illegal  out  1  sticky flag: start seen with non-branch opcode
- taken_cnt  out  CNT_W  branches taken since clr
- nottaken_cnt  out  CNT_W  branches not taken since clr

Behaviour:
- Reset (clr=1 at a rising edge):
  - state <= IDLE; illegal, taken_cnt, nottaken_cnt <= 0.
  - All strobes, busy and done read 0 in the following cycle.
  - clr overrides start and any in-flight state; a reset mid-sequence aborts with no PCIn.
- States: IDLE, T3, T4, T5, T6, FIN.
  - Strobes are Moore outputs decoded from state; each is high for exactly the cycle the FSM sits in that state.
- IDLE:
  - start=1 and IRIn[31:27]==BR_OPCODE -> T3.
  - start=1 with any other opcode -> illegal<=1, stay IDLE, no strobes.
  - start=0 -> stay IDLE.
- T3: Gra=1, Rout=1, CONIn=1 -> T4. CON is valid from T4 on.
- T4: PCout=1, Yin=1 -> T5.
- T5: Cout=1, ALU_ADD=1, Zin=1 -> T6.
- T6: Zlowout=1; PCIn=CON (combinational from the CON sampled this cycle) -> FIN.
  - At the T6->FIN edge: CON=1 increments taken_cnt, otherwise nottaken_cnt.
  - Counters wrap modulo 2^CNT_W.
- FIN: done=1 -> IDLE.
- busy=1 in T3..FIN, 0 in IDLE.
- start while busy is ignored, with no queuing and no effect on illegal.
- Latency: start to done = 5 cycles; back-to-back start is accepted the cycle after done.
- IRIn is only decoded in IDLE. IR changes during T3..FIN do not alter the sequence.
- Exactly one of {Rout, PCout, Cout, Zlowout} is high in T3..T6; none in IDLE/FIN (single bus driver).

Decomposition:
- Shared control package holds:
  - opcode constants (BR_OPCODE and siblings)
  - C2 condition encodings: 00 zero, 01 nonzero, 10 plus, 11 minus
  - state encoding constants, reused by the main control unit for T-step numbering
- One sub-module is natural: br_stat_counter, a CNT_W wrap counter with sync clr and inc. Instantiate it twice.

Test Plan:
- clr held 2 cycles then released -> all outputs 0, counters 0, busy 0.
- IR=0x9000_0000 with R0=0 (brzr, C=0) and a CON model returning 1; pulse start -> exact strobe sequence:
  - T3 Gra/Rout/CONIn
  - T4 PCout/Yin
  - T5 Cout/ALU_ADD/Zin
  - T6 Zlowout+PCIn
  - then done at cycle 5; taken_cnt=1.
- IR=0x9008_0005 (brnz) with CON=0 -> same strobes, PCIn never asserted, nottaken_cnt=1, taken_cnt=0.
- start with IR=0x0800_0000 (non-branch) -> illegal=1, busy stays 0, no strobes; a later valid branch still executes with illegal still 1.
- Second start pulse during T4, then clr asserted in T5 -> second start ignored; next cycle IDLE, PCIn never high, counters 0.
- CNT_W=2, four taken branches back-to-back (start the cycle after each done) -> taken_cnt sequence 1,2,3,0; each done exactly 5 cycles after its start.
